// File: rtl/adf4158_prog.sv
// Serial programming controller for the ADF4158: power-up, then R7..R0 over CLK/DATA/LE.
// Optional lock-detect wait on MUXOUT is enabled by defining ADF4158_LOCK_WAIT_EN.
module adf4158_prog #(
  parameter int          SCLK_DIV  = 4,
  parameter int          PWRUP_CYC = 16,
  parameter logic [31:0] REG0      = 32'h0000_0000,
  parameter logic [31:0] REG1      = 32'h0000_0000,
  parameter logic [31:0] REG2      = 32'h0000_0000,
  parameter logic [31:0] REG3      = 32'h0000_0000,
  parameter logic [31:0] REG4      = 32'h0000_0000,
  parameter logic [31:0] REG5      = 32'h0000_0000,
  parameter logic [31:0] REG6      = 32'h0000_0000,
  parameter logic [31:0] REG7      = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic done_o,
  output logic ce_o,
  output logic le_o,
  output logic clk_o,
  output logic data_o,
  output logic txdata_o,
  input  logic muxout_i
);
  localparam int PER     = 2 * SCLK_DIV;
  localparam int CNT_MAX = (PWRUP_CYC > PER) ? PWRUP_CYC : PER;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HALF_END = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] PER_END  = CW'(PER - 1);
  localparam logic [CW-1:0] PWR_END  = CW'(PWRUP_CYC - 1);
  // 32 data slots followed by two idle serial periods before LE rises
  localparam logic [5:0] LAST_SLOT = 6'd33;

  typedef enum logic [2:0] {
    S_RESET, S_PWRUP, S_SHIFT, S_LATCH, S_GAP, S_LOCKWAIT, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_cnt;
  logic [2:0]    word_idx;
  logic [31:0]   shreg;
  logic [2:0]    load_idx;
  logic [31:0]   load_word;
  logic          load;
  logic          locked;

  function automatic logic [31:0] word_of(input logic [2:0] k);
    logic [31:0] r;
    case (k)
      3'd0:    r = REG0;
      3'd1:    r = REG1;
      3'd2:    r = REG2;
      3'd3:    r = REG3;
      3'd4:    r = REG4;
      3'd5:    r = REG5;
      3'd6:    r = REG6;
      default: r = REG7;
    endcase
    return (r & 32'hFFFF_FFF8) | {29'd0, k};
  endfunction

`ifdef ADF4158_LOCK_WAIT_EN
  logic [1:0] mux_sync;
  always_ff @(posedge clk_i) begin
    if (rst_i) mux_sync <= 2'b00;
    else       mux_sync <= {mux_sync[0], muxout_i};
  end
  assign locked = mux_sync[1];
`else
  logic unused_mux;
  assign unused_mux = muxout_i;
  assign locked     = 1'b1;
`endif

  // Word loads happen after power-up, between words, and on a retrigger from DONE.
  always_comb begin
    load_idx = 3'd7;
    if (state == S_GAP) load_idx = word_idx - 3'd1;
    load = ((state == S_PWRUP) && (cnt == PWR_END)) ||
           ((state == S_GAP) && (cnt == PER_END) && (word_idx != 3'd0)) ||
           ((state == S_DONE) && start_i);
  end
  assign load_word = word_of(load_idx);
  assign txdata_o  = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_RESET;
      cnt      <= '0;
      bit_cnt  <= '0;
      word_idx <= '0;
      shreg    <= '0;
      done_o   <= 1'b0;
      ce_o     <= 1'b0;
      le_o     <= 1'b0;
      clk_o    <= 1'b0;
      data_o   <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          ce_o  <= 1'b1;
          cnt   <= '0;
          state <= S_PWRUP;
        end
        S_PWRUP: cnt <= cnt + 1'b1;
        S_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF_END && bit_cnt < 6'd32) clk_o <= 1'b1;
          if (cnt == PER_END) begin
            cnt   <= '0;
            clk_o <= 1'b0;
            if (bit_cnt == LAST_SLOT) begin
              le_o  <= 1'b1;
              state <= S_LATCH;
            end else begin
              // zeros shift in behind the word, so idle slots drive data low
              bit_cnt <= bit_cnt + 1'b1;
              data_o  <= shreg[31];
              shreg   <= {shreg[30:0], 1'b0};
            end
          end
        end
        S_LATCH: begin
          cnt <= cnt + 1'b1;
          if (cnt == PER_END) begin
            cnt   <= '0;
            le_o  <= 1'b0;
            state <= S_GAP;
          end
        end
        S_GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == PER_END) begin
            cnt <= '0;
            if (word_idx == 3'd0) begin
`ifdef ADF4158_LOCK_WAIT_EN
              state <= S_LOCKWAIT;
`else
              done_o <= 1'b1;
              state  <= S_DONE;
`endif
            end
          end
        end
`ifdef ADF4158_LOCK_WAIT_EN
        S_LOCKWAIT: if (locked) begin
          done_o <= 1'b1;
          state  <= S_DONE;
        end
`endif
        S_DONE: begin
          if (start_i) done_o <= 1'b0;
          else if (!locked) begin
            done_o <= 1'b0;
            state  <= S_LOCKWAIT;
          end
        end
        default: state <= S_RESET;
      endcase
      if (load) begin
        word_idx <= load_idx;
        shreg    <= {load_word[30:0], 1'b0};
        data_o   <= load_word[31];
        cnt      <= '0;
        bit_cnt  <= '0;
        clk_o    <= 1'b0;
        state    <= S_SHIFT;
      end
    end
  end
endmodule

// File: tb/tb_adf4158_prog.sv
// Bench for adf4158_prog: decodes the 3-wire stream into words and compares against
// the register table, with randomized retrigger / stray start / reset points.
module tb_adf4158_prog;
  localparam int SCLK_DIV  = 4;
  localparam int PWRUP_CYC = 16;
  localparam int WORD_CYC  = 36 * 2 * SCLK_DIV;
  localparam int SEQ_CYC   = 8 * WORD_CYC;
`ifdef ADF4158_LOCK_WAIT_EN
  localparam int LOCK_LAT = 1;
`else
  localparam int LOCK_LAT = 0;
`endif
  localparam logic [31:0] R7V = 32'hDEAD_BEEF;

  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, muxout_i = 1'b0;
  logic done_o, ce_o, le_o, clk_o, data_o, txdata_o;

  adf4158_prog #(
    .SCLK_DIV(SCLK_DIV), .PWRUP_CYC(PWRUP_CYC),
    .REG0(32'h0000_0000), .REG1(32'h1111_1110), .REG2(32'h2222_2220),
    .REG3(32'h3333_3330), .REG4(32'h4444_4440), .REG5(32'h5555_5550),
    .REG6(32'h6666_6660), .REG7(R7V)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .done_o(done_o),
    .ce_o(ce_o), .le_o(le_o), .clk_o(clk_o), .data_o(data_o),
    .txdata_o(txdata_o), .muxout_i(muxout_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  int cyc = 0, t_first_rise = -1, t_done = -1, inv_err = 0;
  int nb = 0, le_w = 0, le_w_last = -1;
  logic [31:0] sh = '0;
  logic [31:0] cap_q[$];
  int nb_q[$];
  logic prev_clk = 1'b0, prev_le = 1'b0, prev_done = 1'b0, prev_data = 1'b0;

  // Reference: word k carries REGk[31:3] with its index in the control bits.
  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] r;
    r = (k == 7) ? R7V : 32'h1111_1110 * k;
    return {r[31:3], 3'(k)};
  endfunction

  // Bus monitor: sample just after each active edge.
  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (rst_i) begin
      nb = 0; sh = '0; le_w = 0;
    end else begin
      if (clk_o && !prev_clk) begin
        sh = {sh[30:0], data_o};
        nb++;
        if (t_first_rise < 0) t_first_rise = cyc;
      end
      if (le_o && !prev_le) begin
        cap_q.push_back(sh); nb_q.push_back(nb); nb = 0;
      end
      if (le_o) le_w++;
      else if (prev_le) begin le_w_last = le_w; le_w = 0; end
      if (done_o && !prev_done) t_done = cyc;
    end
    if (le_o && clk_o) inv_err++;
    if (clk_o && data_o !== prev_data) inv_err++;
    if (txdata_o !== 1'b0) inv_err++;
    prev_clk = clk_o; prev_le = le_o; prev_done = done_o; prev_data = data_o;
  end

  int seq_start;

  task automatic wait_posedge();
    @(posedge clk_i); #2;
  endtask

  task automatic test_reset();
    int c0;
    rst_i = 1'b1;
    repeat (5) @(negedge clk_i);
    checks++;
    if ({done_o, ce_o, le_o, clk_o, data_o, txdata_o} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 000000",
        {done_o, ce_o, le_o, clk_o, data_o, txdata_o});
    end
    cap_q.delete(); nb_q.delete(); t_first_rise = -1; t_done = -1;
    rst_i = 1'b0;
    wait_posedge();
    c0 = cyc;
    checks++;
    if ({ce_o, clk_o, done_o} !== 3'b100) begin
      errors++; $display("FAIL ce_after_release got ce=%b clk=%b done=%b want 1 0 0", ce_o, clk_o, done_o);
    end
    for (int n = 0; n < 100 && t_first_rise < 0; n++) wait_posedge();
    checks++;
    if (t_first_rise != c0 + PWRUP_CYC + SCLK_DIV) begin
      errors++; $display("FAIL first_sclk_rise got %0d want %0d", t_first_rise - c0 + 1,
        1 + PWRUP_CYC + SCLK_DIV);
    end
    seq_start = c0 + PWRUP_CYC;
  endtask

  task automatic test_word_content();
    for (int n = 0; n < 2 * WORD_CYC && cap_q.size() < 1; n++) wait_posedge();
    checks++;
    if (cap_q.size() < 1 || cap_q[0] !== exp_word(7) || nb_q[0] != 32) begin
      errors++; $display("FAIL word_r7 got %h (%0d bits) want %h (32 bits)",
        (cap_q.size() > 0) ? cap_q[0] : 32'hx, (nb_q.size() > 0) ? nb_q[0] : -1, exp_word(7));
    end
    for (int n = 0; n < 4 * SCLK_DIV && le_o; n++) wait_posedge();
    checks++;
    if (le_w_last != 2 * SCLK_DIV) begin
      errors++; $display("FAIL le_width got %0d want %0d", le_w_last, 2 * SCLK_DIV);
    end
  endtask

  task automatic test_full_sequence(input string tag);
    int bad_nb;
    for (int n = 0; n < SEQ_CYC + 500 && t_done < 0; n++) wait_posedge();
    checks++;
    if (t_done != seq_start + SEQ_CYC + LOCK_LAT) begin
      errors++; $display("FAIL %s done_time got %0d want %0d", tag, t_done - seq_start,
        SEQ_CYC + LOCK_LAT);
    end
    checks++;
    if (cap_q.size() != 8) begin
      errors++; $display("FAIL %s word_count got %0d want 8", tag, cap_q.size());
    end else begin
      bad_nb = 0;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (cap_q[i] !== exp_word(7 - i)) begin
          errors++; $display("FAIL %s word%0d got %h want %h", tag, i, cap_q[i], exp_word(7 - i));
        end
        if (nb_q[i] != 32) bad_nb++;
      end
      checks++;
      if (bad_nb != 0) begin
        errors++; $display("FAIL %s bits_per_word got %0d bad words want 0", tag, bad_nb);
      end
    end
    checks++;
    if (inv_err != 0) begin
      errors++; $display("FAIL %s bus_rules got %0d violations want 0", tag, inv_err);
    end
  endtask

  // Pulses start_i in DONE and returns the cycle at which it was sampled.
  task automatic retrigger(output int cs);
    repeat ($urandom_range(1, 20)) @(negedge clk_i);
    cap_q.delete(); nb_q.delete(); t_first_rise = -1; t_done = -1;
    start_i = 1'b1;
    wait_posedge();
    cs = cyc;
    @(negedge clk_i) start_i = 1'b0;
  endtask

  task automatic test_retrigger();
    int cs;
    retrigger(cs);
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL retrigger_done_low got %b want 0", done_o);
    end
    for (int n = 0; n < 50 && t_first_rise < 0; n++) wait_posedge();
    checks++;
    if (t_first_rise != cs + SCLK_DIV) begin
      errors++; $display("FAIL retrigger_first_rise got %0d want %0d", t_first_rise - cs, SCLK_DIV);
    end
    // stray start while shifting must not disturb anything
    repeat ($urandom_range(20, 2000)) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    seq_start = cs;
    test_full_sequence("retrigger");
  endtask

  task automatic test_mid_reset();
    int cs;
    retrigger(cs);
    for (int n = 0; n < 4 * WORD_CYC && cap_q.size() < 3; n++) wait_posedge();
    repeat ($urandom_range(20, 250)) @(negedge clk_i);
    rst_i = 1'b1;
    wait_posedge();
    checks++;
    if ({done_o, ce_o, le_o, clk_o, data_o} !== 5'b0 || cap_q.size() != 3) begin
      errors++; $display("FAIL mid_reset got outs=%b words=%0d want 00000 words=3",
        {done_o, ce_o, le_o, clk_o, data_o}, cap_q.size());
    end
    test_reset();
    test_full_sequence("after_reset");
  endtask

`ifdef ADF4158_LOCK_WAIT_EN
  task automatic test_lock_wait();
    int cs, n;
    muxout_i = 1'b0;
    repeat (4) @(negedge clk_i);
    retrigger(cs);
    for (n = 0; n < SEQ_CYC + 500 && cap_q.size() < 8; n++) wait_posedge();
    repeat (50) wait_posedge();
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL lock_hold got done=%b want 0", done_o);
    end
    @(negedge clk_i) muxout_i = 1'b1;
    for (n = 0; n < 3 && !done_o; n++) wait_posedge();
    checks++;
    if (done_o !== 1'b1) begin
      errors++; $display("FAIL lock_rise got done=%b want 1", done_o);
    end
    @(negedge clk_i) muxout_i = 1'b0;
    for (n = 0; n < 3 && done_o; n++) wait_posedge();
    checks++;
    if (done_o !== 1'b0) begin
      errors++; $display("FAIL lock_loss got done=%b want 0", done_o);
    end
    muxout_i = 1'b1;
    repeat (5) @(negedge clk_i);
  endtask
`endif

  initial begin
    muxout_i = (LOCK_LAT != 0);
    test_reset();
    test_word_content();
    test_full_sequence("power_up");
    test_retrigger();
    test_mid_reset();
`ifdef ADF4158_LOCK_WAIT_EN
    test_lock_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adf4158_prog.md
Name: adf4158_prog

Overview:
- Serial programming controller for the ADF4158 FMCW PLL synthesizer, clocked from the 40 MHz board clock.
- After reset it powers up the chip, then shifts the eight 32-bit configuration words R7..R0 over the 3-wire interface (CLK/DATA/LE).
- Signals completion on done_o and can be retriggered to reprogram.
- txdata_o is held low; FSK/PSK modulation is unused.

Parameters:
- SCLK_DIV, 4: clk_i cycles per half-period of clk_o. Serial clock period = 2*SCLK_DIV cycles (5 MHz at 40 MHz).
- PWRUP_CYC, 16: clk_i cycles between ce_o rising and the first serial bit.
- REG0..REG7, 32'h0000_0000 each: payloads for R0..R7. Bits [2:0] are ignored and replaced by the register index.

Ports:
- clk_i  in  1  system clock, 40 MHz
- rst_i  in  1  synchronous reset, active high
- start_i  in  1  one-cycle reprogram request
- done_o  out  1  high when all 8 words have been loaded
- ce_o  out  1  ADF4158 chip enable
- le_o  out  1  load enable, latches the shifted word
- clk_o  out  1  serial clock to the ADF4158
- data_o  out  1  serial data, MSB first
- txdata_o  out  1  ADF4158 TXDATA pin, constant 0
- muxout_i  in  1  ADF4158 MUXOUT (used only with the optional feature)

Behaviour:
- Reset (rst_i high at a clk_i edge): all outputs 0 on the next edge; state=RESET; counters cleared.
- rst_i asserted mid-operation aborts the current transfer immediately. The sequence restarts from power-up after release.
- States: RESET -> PWRUP -> SHIFT -> LATCH -> GAP -> (next word: SHIFT | DONE).
- RESET: first cycle with rst_i low sets ce_o=1 (ce_o stays 1 until the next reset), then goes to PWRUP.
- PWRUP: waits PWRUP_CYC cycles, then loads word R7 into a 32-bit shift register.
- Word k = {REGk[31:3], k[2:0]}. Load order: R7, R6, R5, R4, R3, R2, R1, R0.
- SHIFT, per bit (31 down to 0):
  - Low phase: clk_o=0 for SCLK_DIV cycles; data_o=current bit, updated at the start of the low phase.
  - High phase: clk_o=1 for SCLK_DIV cycles; data_o held stable.
- After bit 0's high phase, clk_o returns to 0 and data_o returns to 0.
- LATCH: le_o=1 for 2*SCLK_DIV cycles, clk_o=0.
- GAP: le_o=0 for 2*SCLK_DIV cycles.
- After GAP: if R0 has been sent, go to DONE; else load the next word and return to SHIFT.
- Per-word cost = 36*2*SCLK_DIV cycles (288 at default). 8 words = 2304 cycles.
- DONE: done_o=1; clk_o, le_o, data_o all 0.
- start_i in DONE: done_o=0 on the next edge; the sequence restarts at R7 directly, with no PWRUP.
- start_i in any state other than DONE is ignored.
- le_o and clk_o are never high in the same cycle.
- data_o changes only while clk_o=0.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ADF4158_LOCK_WAIT_EN.
- Defined:
  - muxout_i is synchronized through 2 flops.
  - After the final GAP, state LOCKWAIT holds done_o=0 until the synchronized muxout_i is high (lock detect), then enters DONE.
  - If lock is lost while in DONE, done_o drops to 0 and the block returns to LOCKWAIT.
- Undefined: muxout_i is unused; DONE is entered directly after the final GAP.

Test Plan:
- Reset/power-up: hold rst_i 5 cycles, release -> all outputs 0 during reset; ce_o=1 one cycle after release; first clk_o rising edge at 1+PWRUP_CYC+SCLK_DIV cycles after release.
- Word content: REG7=32'hDEAD_BEEF -> first 32 bits sampled on clk_o rising edges = 32'hDEAD_BEEF (bits [2:0] = 3'b111). Then one le_o pulse, 8 cycles wide.
- Full sequence: REGk = 32'h1111_1110*k -> 8 words captured, control bits 7,6,...,0 in order. done_o rises 2304 cycles after the first shift bit begins. txdata_o=0 throughout.
- Retrigger: start_i pulse in DONE -> done_o low next cycle, R7 shifting starts without a power-up delay. A start_i pulse during SHIFT leaves the sequence unchanged.
- Mid-operation reset: assert rst_i during word R4 -> outputs 0 next cycle. After release, the sequence restarts from power-up with R7.
- ADF4158_LOCK_WAIT_EN: muxout_i=0 after R0 -> done_o stays 0. Raise muxout_i -> done_o=1 within 3 cycles. Drop muxout_i -> done_o=0 within 3 cycles.
